pfiform_pop_unpacker: RTL
=========================

# pfiform_pop_unpacker

Pop-side consumer for the PFIFORM variable-width element FIFO. It drives `PopPermit`/`PopAmout` and accepts `PopAmout+1` six-bit elements per `PopEnable` transfer from the 192-bit `PopData` bus. It buffers up to two popped words and replays their elements one per cycle on a valid/ready element stream. It sits between PFIFORM and any single-element downstream consumer, such as the per-element checker or a symbol mapper.

## Interface
Parameters:
- `ELEM_W`, 6, bits per element
- `ELEM_N`, 32, elements per bus word; bus width is `ELEM_W*ELEM_N` = 192
- `CNT_W`, 5, width of amount and index fields; `ELEM_N` = 2^`CNT_W`

Ports:
- `i_core_clk`  in  1  single clock, rising edge
- `i_rx_rstn`  in  1  reset, asynchronous assert, active-low
- `i_cfg_amount`  in  `CNT_W`  elements-minus-one requested per pop
- `PopAmout`  out  `CNT_W`  amount presented to PFIFORM (registered)
- `PopPermit`  out  1  unpacker can accept a word this cycle (registered)
- `PopEnable`  in  1  PFIFORM presents a word; with `PopPermit`=1 this is a transfer
- `PopData`  in  192  popped word; element k is in bits [6k+5:6k]
- `o_elem`  out  `ELEM_W`  current output element
- `o_elem_valid`  out  1  `o_elem` valid
- `i_elem_ready`  in  1  downstream accepts `o_elem`
- `o_elem_last`  out  1  `o_elem` is the final element of its word
- `o_proto_err`  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- Storage:
  - two word slots (ping-pong), each holding 192 data bits and a `CNT_W` amount tag;
  - a 2-bit occupancy counter `occ` (0..2);
  - write pointer `wp`, read pointer `rp` and element index `idx`.
- Transfer:
  - A transfer occurs on a cycle with `PopEnable`=1 and `PopPermit`=1.
  - `PopData` is written to slot `wp` with tag `PopAmout`.
  - `wp` toggles.
- Amount:
  - `PopAmout` loads `i_cfg_amount` out of reset and on every transfer cycle. It is otherwise held.
  - The value PFIFORM sees while `PopPermit` is high is therefore constant until a transfer.
- Element stream:
  - `o_elem_valid` = (`occ`≠0).
  - `o_elem` = slot[`rp`] element `idx`.
  - `o_elem_last` = `o_elem_valid` and (`idx` == tag[`rp`]).
- Element accept (`o_elem_valid` and `i_elem_ready`):
  - If not last: `idx`+1.
  - If last: `idx`←0, `rp` toggles, the slot is freed.
- Occupancy: `occ_next` = `occ` + transfer − slot_free. A simultaneous transfer and free leaves `occ` unchanged.
- Permit: `PopPermit` ← (`occ_next` < 2). A transfer that fills the second slot drops `PopPermit` on the following cycle.
- Amount 0: single-element words; every element is last.
- Amount 31: all 32 elements are replayed. `idx` never wraps past the tag.
- Elements beyond the tag in `PopData` are ignored.

## Timing
- Reset values:
  - `PopPermit`=0, `PopAmout`=0, `o_elem_valid`=0, `o_elem_last`=0, `o_elem`=0, `o_proto_err`=0;
  - `occ`=`wp`=`rp`=`idx`=0.
- First cycle after reset release: `PopPermit`=1, `PopAmout`=`i_cfg_amount`.
- Latency: a transfer at edge N gives `o_elem_valid`=1 with element 0 from edge N+1.
- Throughput: one element per cycle with `i_elem_ready` held high. Back-to-back words stream with no gap cycle.
- A word of amount A occupies its slot for at least A+1 cycles.
- `PopEnable` with `PopPermit`=0 is not a transfer. No slot, pointer or `PopAmout` state changes.
- A downstream stall (`i_elem_ready`=0) holds `o_elem`, `idx` and `o_elem_last` stable.
- Reset asserted mid-word: all state returns to reset values immediately. Buffered elements are discarded.

## Configuration
- Macro `PFIFORM_UNPACK_ERR_EN`.
- Defined: `o_proto_err` sets on any cycle with `PopEnable`=1 and `PopPermit`=0, and clears only by reset.
- Undefined: `o_proto_err` is tied to 0 and the detection logic is absent.
- Data-path behaviour is identical in both builds.

## Test plan
- Reset, `i_cfg_amount`=9, PFIFORM holds words 0..255 pattern, ready=1 → `PopAmout`=9; elements 0..9 in order, `o_elem_last` on element 9, next word follows with no gap.
- `i_cfg_amount`=18 then 9 mid-stream, as the PFIFORM bench switches at 2290 ns → each word replays exactly its own tag+1 elements (19, then 10). `PopAmout` changes only on a transfer cycle.
- Hold `i_elem_ready`=0 after two transfers → `occ`=2, `PopPermit`=0 on the next cycle, `o_elem` stable. Release ready → permit returns one cycle after the first slot frees.
- Amount 0 and amount 31 words back-to-back → 1 element (last) then 32 elements, with element 31 taken from `PopData[191:186]`.
- With `PFIFORM_UNPACK_ERR_EN`, drive `PopEnable`=1 while `PopPermit`=0 → `o_proto_err`=1 next cycle and stays set, with no change to the element stream. Without the macro, `o_proto_err` stays 0.
- Assert `i_rx_rstn`=0 mid-word (idx=5) → all outputs at reset values immediately. After release, the first element out is element 0 of a new word.

Source files
------------

// File: rtl/pfiform_pop_unpacker.sv
// pfiform_pop_unpacker
// Pop-side consumer for the PFIFORM variable-width element FIFO. Pops whole
// words of (PopAmout+1) elements into a two-slot ping-pong buffer and replays
// them one element per cycle on a valid/ready stream.
// Optional build macro: PFIFORM_UNPACK_ERR_EN enables the sticky o_proto_err
// detector (PopEnable seen while PopPermit is low). Without it o_proto_err is 0.
//
// Handshakes: a beat moves only on a cycle where both sides agree. On the pop
// side that is PopEnable=1 with PopPermit=1; on the element side it is
// o_elem_valid=1 with i_elem_ready=1. While valid is high and ready is low,
// o_elem and o_elem_last hold stable; valid never drops without an accept.
module pfiform_pop_unpacker #(
    parameter int ELEM_W = 6,
    parameter int ELEM_N = 32,
    parameter int CNT_W  = 5
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic [CNT_W-1:0]         i_cfg_amount,
    output logic [CNT_W-1:0]         PopAmout,
    output logic                     PopPermit,
    input  logic                     PopEnable,
    input  logic [ELEM_W*ELEM_N-1:0] PopData,
    output logic [ELEM_W-1:0]        o_elem,
    output logic                     o_elem_valid,
    input  logic                     i_elem_ready,
    output logic                     o_elem_last,
    output logic                     o_proto_err
);

    localparam int BUS_W = ELEM_W * ELEM_N;

    logic [BUS_W-1:0]  slot_q [2];
    logic [BUS_W-1:0]  slot_d [2];
    logic [CNT_W-1:0]  tag_q  [2];
    logic [CNT_W-1:0]  tag_d  [2];
    logic [1:0]        occ_q, occ_d;
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  amount_q, amount_d;
    logic              permit_q, permit_d;
    // Low only on the first cycle out of reset, so PopAmout picks up the config then.
    logic              loaded_q, loaded_d;

    logic              transfer;
    logic              elem_valid;
    logic              elem_last;
    logic              accept;
    logic              slot_free;
    logic [ELEM_W-1:0] elems [ELEM_N];

    assign transfer   = PopEnable & permit_q;
    assign elem_valid = (occ_q != 2'd0);
    assign elem_last  = elem_valid & (idx_q == tag_q[rp_q]);
    assign accept     = elem_valid & i_elem_ready;
    assign slot_free  = accept & elem_last;

    // Split the slot being read into addressable elements.
    for (genvar g = 0; g < ELEM_N; g++) begin : g_elem
        assign elems[g] = slot_q[rp_q][g*ELEM_W +: ELEM_W];
    end

    // Output is forced to zero while empty so it reads 0 out of reset.
    assign o_elem       = elem_valid ? elems[idx_q] : '0;
    assign o_elem_valid = elem_valid;
    assign o_elem_last  = elem_last;
    assign PopAmout     = amount_q;
    assign PopPermit    = permit_q;

    // Next-state: slot write on transfer, element walk on accept, occupancy and permit.
    always_comb begin
        slot_d   = slot_q;
        tag_d    = tag_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        idx_d    = idx_q;
        amount_d = amount_q;
        loaded_d = 1'b1;

        if (transfer) begin
            slot_d[wp_q] = PopData;
            tag_d[wp_q]  = amount_q;
            wp_d         = ~wp_q;
        end

        if (accept) begin
            if (elem_last) begin
                idx_d = '0;
                rp_d  = ~rp_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        occ_d    = occ_q + {1'b0, transfer} - {1'b0, slot_free};
        permit_d = (occ_d < 2'd2);

        if (!loaded_q || transfer) begin
            amount_d = i_cfg_amount;
        end
    end

    // Control state: pointers, occupancy, tags, amount and permit.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            tag_q[0] <= '0;
            tag_q[1] <= '0;
            occ_q    <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            idx_q    <= '0;
            amount_q <= '0;
            permit_q <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            tag_q[0] <= tag_d[0];
            tag_q[1] <= tag_d[1];
            occ_q    <= occ_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            idx_q    <= idx_d;
            amount_q <= amount_d;
            permit_q <= permit_d;
            loaded_q <= loaded_d;
        end
    end

    // Slot data needs no reset: it is only observed while occupancy marks it valid.
    always_ff @(posedge i_core_clk) begin
        slot_q[0] <= slot_d[0];
        slot_q[1] <= slot_d[1];
    end

`ifdef PFIFORM_UNPACK_ERR_EN
    logic err_q, err_d;

    // Sticky flag for a pop attempt while permit is withheld.
    always_comb begin
        err_d = err_q | (PopEnable & ~permit_q);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_proto_err = err_q;
`else
    assign o_proto_err = 1'b0;
`endif

endmodule
